// File: rtl/multiport_reg_file_pkg.sv
// ---------------------------------------------------------------------------
// definitions : shared widths and the register-file state type
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package definitions;
  localparam int DATA_WIDTH = 8;
  localparam int REG_WIDTH  = 4;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_t;
endpackage

`default_nettype wire

// File: rtl/multiport_reg_file_clear_sequencer.sv
// ---------------------------------------------------------------------------
// rf_clear_sequencer : owns the clear sweep, ready and dropped-write flags
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_clear_sequencer
  import definitions::*;
#(
  parameter int REG_WIDTH = definitions::REG_WIDTH
) (
  input  logic                 _CLK,
  input  logic                 _RST,
  input  logic                 _clear,
  input  logic                 anyWrite,
  output logic                 clrEn,
  output logic [REG_WIDTH-1:0] clrIdx,
  output logic                 ready,
  output logic                 writeDropped
);

  localparam logic [REG_WIDTH-1:0] c_ONE  = {{(REG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REG_WIDTH-1:0] c_LAST = {REG_WIDTH{1'b1}};

  rf_state_t            r_state;
  logic [REG_WIDTH-1:0] r_clrIdx;
  logic                 r_ready;
  logic                 r_writeDropped;

  always_ff @(posedge _CLK) begin
    if (_RST) begin
      r_state        <= RF_CLEAR;
      r_clrIdx       <= '0;
      r_ready        <= 1'b0;
      r_writeDropped <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          r_clrIdx       <= r_clrIdx + c_ONE;
          r_writeDropped <= anyWrite;
          if (r_clrIdx == c_LAST) begin
            r_state <= RF_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_writeDropped <= 1'b0;
          if (_clear) begin
            r_state  <= RF_CLEAR;
            r_clrIdx <= '0;
            r_ready  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clrEn        = (r_state == RF_CLEAR);
  assign clrIdx       = r_clrIdx;
  assign ready        = r_ready;
  assign writeDropped = r_writeDropped;

endmodule

`default_nettype wire

// File: rtl/multiport_reg_file.sv
// ---------------------------------------------------------------------------
// multiport_reg_file : N-read / M-write register file with sweep clear
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multiport_reg_file
  import definitions::*;
#(
  parameter int DATA_WIDTH = definitions::DATA_WIDTH,
  parameter int REG_WIDTH  = definitions::REG_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                            _CLK,
  input  logic                            _RST,
  input  logic                            _clear,
  input  logic [NUM_WRITE-1:0]            _regWrite,
  input  logic [NUM_WRITE*REG_WIDTH-1:0]  _regDest,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] _writeVal,
  input  logic [NUM_READ*REG_WIDTH-1:0]   _regSrc,
  output logic [NUM_READ*DATA_WIDTH-1:0]  values,
  output logic                            ready,
  output logic                            writeDropped
);

  localparam int c_DEPTH = 2**REG_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic                  w_clrEn;
  logic [REG_WIDTH-1:0]  w_clrIdx;
  logic                  w_anyWrite;

  assign w_anyWrite = |_regWrite;

  rf_clear_sequencer #(
    .REG_WIDTH (REG_WIDTH)
  ) u_seq (
    ._CLK         (_CLK),
    ._RST         (_RST),
    ._clear       (_clear),
    .anyWrite     (w_anyWrite),
    .clrEn        (w_clrEn),
    .clrIdx       (w_clrIdx),
    .ready        (ready),
    .writeDropped (writeDropped)
  );

  // No reset on the array itself; the sweep zeroes it one entry per cycle.
  // Later ports are visited last so the highest index wins an address clash.
  always_ff @(posedge _CLK) begin
    if (w_clrEn) begin
      r_regs[w_clrIdx] <= '0;
    end else if (!_RST) begin
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (_regWrite[i] &&
            !((ZERO_REG != 0) && (_regDest[i*REG_WIDTH +: REG_WIDTH] == '0))) begin
          r_regs[_regDest[i*REG_WIDTH +: REG_WIDTH]] <= _writeVal[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_read
    logic [REG_WIDTH-1:0]  w_src;
    logic [DATA_WIDTH-1:0] w_rd;

    assign w_src = _regSrc[r*REG_WIDTH +: REG_WIDTH];

    always_comb begin
      w_rd = r_regs[w_src];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (_regWrite[j] && (_regDest[j*REG_WIDTH +: REG_WIDTH] == w_src)) begin
            w_rd = _writeVal[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      if (w_clrEn || ((ZERO_REG != 0) && (w_src == '0))) begin
        w_rd = '0;
      end
    end

    assign values[r*DATA_WIDTH +: DATA_WIDTH] = w_rd;
  end

endmodule

`default_nettype wire

// File: tb/tb_multiport_reg_file.sv
// ---------------------------------------------------------------------------
// tb_multiport_reg_file : directed checks on a bypass and a no-bypass build
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multiport_reg_file;

  logic        _CLK;
  logic        _RST;
  logic        _clear;
  logic [1:0]  _regWrite;
  logic [7:0]  _regDest;
  logic [15:0] _writeVal;
  logic [7:0]  _regSrc;
  logic [15:0] valuesB, valuesN;
  logic        readyB, readyN, dropB, dropN;

  int tests = 0;
  int fails = 0;

  multiport_reg_file #(
    .DATA_WIDTH (8), .REG_WIDTH (4), .NUM_READ (2), .NUM_WRITE (2),
    .ZERO_REG (1), .BYPASS (1)
  ) dutB (
    ._CLK (_CLK), ._RST (_RST), ._clear (_clear), ._regWrite (_regWrite),
    ._regDest (_regDest), ._writeVal (_writeVal), ._regSrc (_regSrc),
    .values (valuesB), .ready (readyB), .writeDropped (dropB)
  );

  multiport_reg_file #(
    .DATA_WIDTH (8), .REG_WIDTH (4), .NUM_READ (2), .NUM_WRITE (2),
    .ZERO_REG (1), .BYPASS (0)
  ) dutN (
    ._CLK (_CLK), ._RST (_RST), ._clear (_clear), ._regWrite (_regWrite),
    ._regDest (_regDest), ._writeVal (_writeVal), ._regSrc (_regSrc),
    .values (valuesN), .ready (readyN), .writeDropped (dropN)
  );

  initial begin
    _CLK = 1'b0;
    forever #5 _CLK = ~_CLK;
  end

  typedef struct {
    logic [1:0] we;
    logic [3:0] d0;
    logic [7:0] v0;
    logic [3:0] d1;
    logic [7:0] v1;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [7:0] eb0;
    logic [7:0] eb1;
    logic [7:0] en0;
    logic [7:0] en1;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge _CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idleInputs();
    _regWrite = 2'b00;
    _regDest  = '0;
    _writeVal = '0;
  endtask

  task automatic readReg(input logic [3:0] a, input logic [7:0] exp, input string nm);
    _regSrc = {a, a};
    #1;
    chk({nm, "_byp"}, {16'h0, valuesB}, {16'h0, exp, exp});
    chk({nm, "_nobyp"}, {16'h0, valuesN}, {16'h0, exp, exp});
  endtask

  // Counts cycles until ready rises on both builds, bounded.
  task automatic waitReady(output int n);
    n = 0;
    while (!(readyB && readyN) && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;

    vecs[0] = '{2'b01, 4'd3,  8'hA5, 4'd0,  8'h00, 4'd3,  4'd0,  8'hA5, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 4'd3,  4'd3,  8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{2'b01, 4'd0,  8'hFF, 4'd0,  8'h00, 4'd0,  4'd0,  8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 4'd0,  4'd3,  8'h00, 8'hA5, 8'h00, 8'hA5};
    vecs[4] = '{2'b11, 4'd7,  8'h22, 4'd7,  8'h33, 4'd7,  4'd3,  8'h33, 8'hA5, 8'h00, 8'hA5};
    vecs[5] = '{2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 4'd7,  4'd7,  8'h33, 8'h33, 8'h33, 8'h33};
    vecs[6] = '{2'b11, 4'd9,  8'h5A, 4'd10, 8'hC3, 4'd10, 4'd9,  8'hC3, 8'h5A, 8'h00, 8'h00};
    vecs[7] = '{2'b01, 4'd9,  8'h01, 4'd0,  8'h00, 4'd9,  4'd10, 8'h01, 8'hC3, 8'h5A, 8'hC3};
    vecs[8] = '{2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 4'd9,  4'd10, 8'h01, 8'hC3, 8'h01, 8'hC3};

    _RST = 1'b1;
    _clear = 1'b0;
    _regSrc = '0;
    idleInputs();

    // Reset sweep
    repeat (3) tick();
    chk("reset_ready", {30'h0, readyB, readyN}, 32'h0);
    chk("reset_drop", {30'h0, dropB, dropN}, 32'h0);
    _RST = 1'b0;
    _regSrc = {4'd5, 4'd12};
    n = 0;
    while (!(readyB && readyN) && n < 40) begin
      chk("sweep_values", {valuesB, valuesN}, 32'h0);
      tick();
      n++;
    end
    chk("sweep_len", n, 16);
    chk("ready_both", {30'h0, readyB, readyN}, 32'h3);
    for (int a = 0; a < 16; a++) readReg(a[3:0], 8'h00, "post_reset_read");

    // Table-driven IDLE traffic
    for (int i = 0; i < 9; i++) begin
      _regWrite = vecs[i].we;
      _regDest  = {vecs[i].d1, vecs[i].d0};
      _writeVal = {vecs[i].v1, vecs[i].v0};
      _regSrc   = {vecs[i].s1, vecs[i].s0};
      #1;
      chk($sformatf("vec%0d_byp", i), {16'h0, valuesB}, {16'h0, vecs[i].eb1, vecs[i].eb0});
      chk($sformatf("vec%0d_nobyp", i), {16'h0, valuesN}, {16'h0, vecs[i].en1, vecs[i].en0});
      chk($sformatf("vec%0d_drop", i), {30'h0, dropB, dropN}, 32'h0);
      tick();
    end
    idleInputs();

    // Dropped write during a requested sweep
    _clear = 1'b1;
    tick();
    _clear = 1'b0;
    _regSrc = {4'd3, 4'd7};
    #1;
    chk("clear_values", {valuesB, valuesN}, 32'h0);
    chk("clear_ready", {30'h0, readyB, readyN}, 32'h0);
    _regWrite = 2'b01;
    _regDest  = {4'd0, 4'd5};
    _writeVal = {8'h00, 8'h11};
    tick();
    idleInputs();
    chk("drop_pulse", {30'h0, dropB, dropN}, 32'h3);
    tick();
    chk("drop_end", {30'h0, dropB, dropN}, 32'h0);
    waitReady(n);
    chk("clear_sweep_rest", n, 14);
    readReg(4'd5, 8'h00, "r5_after_drop");
    readReg(4'd3, 8'h00, "r3_after_clear");

    // Reset in the middle of a sweep
    _regWrite = 2'b01;
    _regDest  = {4'd0, 4'd4};
    _writeVal = {8'h00, 8'h44};
    tick();
    idleInputs();
    readReg(4'd4, 8'h44, "r4_written");
    _clear = 1'b1;
    tick();
    _clear = 1'b0;
    repeat (9) tick();
    chk("mid_sweep_busy", {30'h0, readyB, readyN}, 32'h0);
    _RST = 1'b1;
    repeat (2) tick();
    _RST = 1'b0;
    waitReady(n);
    chk("restart_sweep_len", n, 16);
    readReg(4'd4, 8'h00, "r4_after_restart");
    readReg(4'd15, 8'h00, "r15_after_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
